// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between the decode stage, alu_issue_ctrl
// and the response consumer.
interface alu_issue_ctrl_if #(
  parameter int ALU_SIZE = 8,
  parameter int TAG_W    = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [5:0]          req_opcode;
  logic [5:0]          req_funct;
  logic [ALU_SIZE-1:0] req_a;
  logic [ALU_SIZE-1:0] req_b;
  logic [TAG_W-1:0]    req_tag;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ALU_SIZE-1:0] rsp_data;
  logic                rsp_carry;
  logic [TAG_W-1:0]    rsp_tag;
  logic                rsp_illegal;
  logic                rsp_divz;

  modport master (
    output req_valid, req_opcode, req_funct, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_illegal, rsp_divz
  );

  modport slave (
    input  req_valid, req_opcode, req_funct, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_illegal, rsp_divz
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// MIPS ALU issue stage: request FIFO, opcode/funct decode, ALU drive and response register.
// Optional feature macro: ALU_ISSUE_DIVZ_CHECK_EN (div by zero returns all-ones with rsp_divz).
module alu_issue_ctrl #(
  parameter int ALU_SIZE = 8,
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_ctrl_if.slave     bus,
  output logic [ALU_SIZE-1:0] alu_in_a,
  output logic [ALU_SIZE-1:0] alu_in_b,
  output logic [3:0]          alu_sel,
  input  logic [ALU_SIZE-1:0] alu_out,
  input  logic                carry_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [ALU_SIZE-1:0] a;
    logic [ALU_SIZE-1:0] b;
    logic [TAG_W-1:0]    tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, STALL = 2'd2} state_t;

  entry_t              mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       count_r;
  state_t              state_r, state_s;
  entry_t              in_s, head_s;
  logic                push_s, pop_s, empty_s, full_s, rsp_valid_s;
  logic [3:0]          sel_s;
  logic                illegal_s, swap_s, divz_s, carry_s;
  logic [ALU_SIZE-1:0] result_s;
  logic [ALU_SIZE-1:0] rsp_data_r;
  logic                rsp_carry_r, rsp_illegal_r, rsp_divz_r;
  logic [TAG_W-1:0]    rsp_tag_r;

  assign in_s        = {bus.req_opcode, bus.req_funct, bus.req_a, bus.req_b, bus.req_tag};
  assign head_s      = mem_r[rd_ptr_r];
  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == FULL_CNT);
  assign rsp_valid_s = (state_r != IDLE);
  assign push_s      = bus.req_valid && !full_s;
  // The response slot frees on the same edge it is consumed, so a pop may refill it.
  assign pop_s       = !empty_s && (!rsp_valid_s || bus.rsp_ready);

  assign bus.req_ready   = !full_s;
  assign bus.rsp_valid   = rsp_valid_s;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.rsp_carry   = rsp_carry_r;
  assign bus.rsp_tag     = rsp_tag_r;
  assign bus.rsp_illegal = rsp_illegal_r;
  assign bus.rsp_divz    = rsp_divz_r;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_s;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Opcode/funct decode of the FIFO head
  always_comb begin
    sel_s     = 4'b0000;
    illegal_s = 1'b0;
    swap_s    = 1'b0;
    if (head_s.opcode == 6'h00) begin
      case (head_s.funct)
        6'h20, 6'h21: sel_s = 4'b0000;
        6'h22, 6'h23: sel_s = 4'b0001;
        6'h18:        sel_s = 4'b0010;
        6'h1A:        sel_s = 4'b0011;
        6'h00:        sel_s = 4'b0100;
        6'h02:        sel_s = 4'b0101;
        6'h24:        sel_s = 4'b1000;
        6'h25:        sel_s = 4'b1001;
        6'h26:        sel_s = 4'b1010;
        6'h27:        sel_s = 4'b1011;
        6'h2B: begin
          sel_s  = 4'b1110;
          swap_s = 1'b1;
        end
        default:      illegal_s = 1'b1;
      endcase
    end else begin
      case (head_s.opcode)
        6'h08, 6'h09: sel_s = 4'b0000;
        6'h0C:        sel_s = 4'b1000;
        6'h0D:        sel_s = 4'b1001;
        6'h0E:        sel_s = 4'b1010;
        6'h04:        sel_s = 4'b1111;
        default:      illegal_s = 1'b1;
      endcase
    end
  end

  // ALU operand/select drive; sltu swaps so the ALU's a>b compare yields b>a
  always_comb begin
    alu_in_a = {ALU_SIZE{1'b0}};
    alu_in_b = {ALU_SIZE{1'b0}};
    alu_sel  = 4'b0000;
    if (empty_s) begin
      alu_sel = 4'b0000;
    end else if (swap_s) begin
      alu_in_a = head_s.b;
      alu_in_b = head_s.a;
      alu_sel  = sel_s;
    end else begin
      alu_in_a = head_s.a;
      alu_in_b = head_s.b;
      alu_sel  = sel_s;
    end
  end

`ifdef ALU_ISSUE_DIVZ_CHECK_EN
  assign divz_s = !illegal_s && (sel_s == 4'b0011) && (head_s.b == {ALU_SIZE{1'b0}});
`else
  assign divz_s = 1'b0;
`endif

  // Response value selection
  always_comb begin
    result_s = alu_out;
    carry_s  = 1'b0;
    if (illegal_s) begin
      result_s = {ALU_SIZE{1'b0}};
    end else if (divz_s) begin
      result_s = {ALU_SIZE{1'b1}};
    end else if (sel_s == 4'b0000) begin
      carry_s = carry_out;
    end else begin
      carry_s = 1'b0;
    end
  end

  // Control FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Control FSM next state; any non-IDLE state means the response slot is full
  always_comb begin
    state_s = state_r;
    if (pop_s) begin
      state_s = ISSUE;
    end else if (rsp_valid_s && !bus.rsp_ready) begin
      state_s = STALL;
    end else begin
      state_s = IDLE;
    end
  end

  // Response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_r    <= {ALU_SIZE{1'b0}};
      rsp_carry_r   <= 1'b0;
      rsp_tag_r     <= {TAG_W{1'b0}};
      rsp_illegal_r <= 1'b0;
      rsp_divz_r    <= 1'b0;
    end else if (pop_s) begin
      rsp_data_r    <= result_s;
      rsp_carry_r   <= carry_s;
      rsp_tag_r     <= head_s.tag;
      rsp_illegal_r <= illegal_s;
      rsp_divz_r    <= divz_s;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] alu_in_a, alu_in_b, alu_out;
  logic [3:0] alu_sel;
  logic       carry_out;

  int checks = 0;
  int failures = 0;

  logic        acc, got;
  logic [14:0] cap;
  logic [14:0] sb[$];

  alu_issue_ctrl_if #(.ALU_SIZE(8), .TAG_W(4)) bus ();

  alu_issue_ctrl #(.ALU_SIZE(8), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; carry is 1 on non-add ops so leaks into rsp_carry show up
  always_comb begin
    alu_out   = 8'h00;
    carry_out = 1'b1;
    case (alu_sel)
      4'b0000: {carry_out, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b};
      4'b0001: alu_out = alu_in_a - alu_in_b;
      4'b0010: alu_out = alu_in_a * alu_in_b;
      4'b0011: alu_out = (alu_in_b == 8'h00) ? 8'h5A : alu_in_a / alu_in_b;
      4'b0100: alu_out = alu_in_a << alu_in_b[2:0];
      4'b0101: alu_out = alu_in_a >> alu_in_b[2:0];
      4'b1000: alu_out = alu_in_a & alu_in_b;
      4'b1001: alu_out = alu_in_a | alu_in_b;
      4'b1010: alu_out = alu_in_a ^ alu_in_b;
      4'b1011: alu_out = ~(alu_in_a | alu_in_b);
      4'b1110: alu_out = (alu_in_a > alu_in_b) ? 8'h01 : 8'h00;
      4'b1111: alu_out = (alu_in_a == alu_in_b) ? 8'h01 : 8'h00;
      default: alu_out = 8'hEE;
    endcase
  end

  // Expected response {illegal, divz, carry, tag, data} straight from the request
  function automatic logic [14:0] exp_rsp(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] tag);
    logic [8:0] s;
    logic [7:0] d;
    logic       c, ill, dz;
    s = {1'b0, a} + {1'b0, b};
    d = 8'h00; c = 1'b0; ill = 1'b0; dz = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: begin d = s[7:0]; c = s[8]; end
        6'h22, 6'h23: d = a - b;
        6'h18:        d = a * b;
        6'h1A: begin
          if (b != 8'h00) d = a / b;
`ifdef ALU_ISSUE_DIVZ_CHECK_EN
          else begin d = 8'hFF; dz = 1'b1; end
`else
          else d = 8'h5A;
`endif
        end
        6'h00:   d = a << b[2:0];
        6'h02:   d = a >> b[2:0];
        6'h24:   d = a & b;
        6'h25:   d = a | b;
        6'h26:   d = a ^ b;
        6'h27:   d = ~(a | b);
        6'h2B:   d = (a < b) ? 8'h01 : 8'h00;
        default: ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin d = s[7:0]; c = s[8]; end
        6'h0C:   d = a & b;
        6'h0D:   d = a | b;
        6'h0E:   d = a ^ b;
        6'h04:   d = (a == b) ? 8'h01 : 8'h00;
        default: ill = 1'b1;
      endcase
    end
    return {ill, dz, c, tag, d};
  endfunction

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tag);
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_funct = fn;
    bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
  endtask

  // One clock: note handshakes seen before the edge, push expectations, land #1 after the edge
  task automatic step();
    acc = bus.req_valid && bus.req_ready;
    got = bus.rsp_valid && bus.rsp_ready;
    cap = {bus.rsp_illegal, bus.rsp_divz, bus.rsp_carry, bus.rsp_tag, bus.rsp_data};
    if (acc) sb.push_back(exp_rsp(bus.req_opcode, bus.req_funct, bus.req_a, bus.req_b, bus.req_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_divz, bus.rsp_carry, bus.rsp_tag, bus.rsp_data} !== 16'h0000) begin
      failures++; $display("FAIL reset_rsp got=%h exp=0000",
        {bus.rsp_valid, bus.rsp_illegal, bus.rsp_divz, bus.rsp_carry, bus.rsp_tag, bus.rsp_data});
    end
    checks++;
    if ({alu_sel, alu_in_a, alu_in_b} !== 20'h00000) begin
      failures++; $display("FAIL reset_alu got=%h exp=00000", {alu_sel, alu_in_a, alu_in_b});
    end
  endtask

  task automatic test_addu();
    bus.rsp_ready = 1'b1;
    issue(6'h00, 6'h21, 8'hF0, 8'h20, 4'd3);
    step();
    bus.req_valid = 1'b0;
    checks++;
    if ({alu_sel, alu_in_a, alu_in_b} !== {4'b0000, 8'hF0, 8'h20}) begin
      failures++; $display("FAIL addu_alu got=%h exp=%h", {alu_sel, alu_in_a, alu_in_b}, {4'b0000, 8'hF0, 8'h20});
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL addu_early_valid got=%b exp=0", bus.rsp_valid); end
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_tag, bus.rsp_illegal} !== {1'b1, 8'h10, 1'b1, 4'd3, 1'b0}) begin
      failures++; $display("FAIL addu_rsp got=%h exp=%h",
        {bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_tag, bus.rsp_illegal}, {1'b1, 8'h10, 1'b1, 4'd3, 1'b0});
    end
    step();
    checks++;
    if (!got || sb.size() == 0) begin failures++; $display("FAIL addu_sb got=%b exp=1", got); end
    else if (cap !== sb[0]) begin failures++; $display("FAIL addu_sb got=%h exp=%h", cap, sb[0]); void'(sb.pop_front()); end
    else void'(sb.pop_front());
  endtask

  task automatic test_sltu();
    bus.rsp_ready = 1'b1;
    issue(6'h00, 6'h2B, 8'h05, 8'h09, 4'd7);
    step();
    bus.req_valid = 1'b0;
    checks++;
    if ({alu_sel, alu_in_a, alu_in_b} !== {4'b1110, 8'h09, 8'h05}) begin
      failures++; $display("FAIL sltu_alu got=%h exp=%h", {alu_sel, alu_in_a, alu_in_b}, {4'b1110, 8'h09, 8'h05});
    end
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_carry} !== {1'b1, 8'h01, 1'b0}) begin
      failures++; $display("FAIL sltu_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_data, bus.rsp_carry}, {1'b1, 8'h01, 1'b0});
    end
    step();
    if (got && sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_illegal();
    bus.rsp_ready = 1'b1;
    issue(6'h00, 6'h3F, 8'hFF, 8'h01, 4'd9);
    step();
    bus.req_valid = 1'b0;
    checks++;
    if (alu_sel !== 4'b0000) begin failures++; $display("FAIL illegal_sel got=%b exp=0000", alu_sel); end
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_carry} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      failures++; $display("FAIL illegal_rsp got=%h exp=%h",
        {bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_carry}, {1'b1, 1'b1, 8'h00, 1'b0});
    end
    step();
    if (got && sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_divz();
    logic [8:0] exp;
`ifdef ALU_ISSUE_DIVZ_CHECK_EN
    exp = {1'b1, 8'hFF};
`else
    exp = {1'b0, 8'h5A};
`endif
    bus.rsp_ready = 1'b1;
    issue(6'h00, 6'h1A, 8'h40, 8'h00, 4'd2);
    step();
    bus.req_valid = 1'b0;
    step();
    checks++;
    if ({bus.rsp_divz, bus.rsp_data} !== exp) begin
      failures++; $display("FAIL divz_rsp got=%h exp=%h", {bus.rsp_divz, bus.rsp_data}, exp);
    end
    step();
    if (got && sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [5:0] op_t [18] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h04, 6'h3F};
    logic [5:0] fn_t [18] = '{6'h20, 6'h22, 6'h23, 6'h18, 6'h1A, 6'h00, 6'h02, 6'h24, 6'h25,
                              6'h27, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    int n;
    bus.rsp_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 18; i++) begin
        issue(op_t[i], fn_t[i], 8'($urandom), (i == 15) ? 8'h00 : 8'($urandom_range(1, 255)), 4'(i));
        if (i == 16) bus.req_b = bus.req_a;
        step();
        checks++;
        if (!acc) begin failures++; $display("FAIL b2b_accept idx=%0d got=0 exp=1", i); end
        if (got) begin
          checks++;
          if (sb.size() == 0) begin failures++; $display("FAIL b2b_rsp extra got=%h", cap); end
          else begin
            if (cap !== sb[0]) begin failures++; $display("FAIL b2b_rsp got=%h exp=%h", cap, sb[0]); end
            void'(sb.pop_front());
          end
        end
      end
      bus.req_valid = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 40) begin
        step();
        n++;
        if (got) begin
          checks++;
          if (cap !== sb[0]) begin failures++; $display("FAIL b2b_rsp got=%h exp=%h", cap, sb[0]); end
          void'(sb.pop_front());
        end
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL b2b_timeout pending=%0d exp=0", sb.size()); sb.delete(); end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int gots = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (k < 6) issue(6'h00, 6'h21, 8'(k), 8'h01, 4'(k));
      else bus.req_valid = 1'b0;
      step();
      if (acc) k++;
      if (bus.rsp_valid && sb.size() != 0) begin
        checks++;
        if ({bus.rsp_illegal, bus.rsp_divz, bus.rsp_carry, bus.rsp_tag, bus.rsp_data} !== sb[0]) begin
          failures++; $display("FAIL bp_hold got=%h exp=%h",
            {bus.rsp_illegal, bus.rsp_divz, bus.rsp_carry, bus.rsp_tag, bus.rsp_data}, sb[0]);
        end
      end
    end
    checks++;
    if (k !== 5 || bus.req_ready !== 1'b0) begin
      failures++; $display("FAIL bp_capacity got=%0d/%b exp=5/0", k, bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (k < 6) issue(6'h00, 6'h21, 8'(k), 8'h01, 4'(k));
      else bus.req_valid = 1'b0;
      step();
      if (acc) k++;
      if (got) begin
        gots++;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL bp_order extra got=%h", cap); end
        else begin
          if (cap !== sb[0]) begin failures++; $display("FAIL bp_order got=%h exp=%h", cap, sb[0]); end
          void'(sb.pop_front());
        end
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (gots !== 6 || k !== 6) begin failures++; $display("FAIL bp_drain got=%0d/%0d exp=6/6", gots, k); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(6'h0D, 6'h00, 8'h11, 8'(i), 4'(8 + i));
      step();
    end
    bus.req_valid = 1'b0;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", bus.rsp_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, alu_sel, bus.req_ready, bus.rsp_data} !== {1'b0, 4'b0000, 1'b1, 8'h00}) begin
      failures++; $display("FAIL rstmid_clear got=%h exp=%h",
        {bus.rsp_valid, alu_sel, bus.req_ready, bus.rsp_data}, {1'b0, 4'b0000, 1'b1, 8'h00});
    end
    #2 rst_n = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (got || bus.rsp_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin failures++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_opcode = 6'h00; bus.req_funct = 6'h00;
    bus.req_a = 8'h00; bus.req_b = 8'h00; bus.req_tag = 4'h0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_addu();
    test_sltu();
    test_illegal();
    test_divz();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
